// File: rtl/mcu_spi_sync.sv
// Single-clock MCU SPI (mode 1) byte interface: oversamples the SPI pins in the core
// clock domain, decodes a target ID from the first byte and fans data bytes out to core targets.
module mcu_spi_sync #(
  parameter int NUM_TARGETS = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spi_io_ss,
  input  logic                     spi_io_clk,
  input  logic                     spi_io_din,
  output logic                     spi_io_dout,
  output logic [NUM_TARGETS-1:0]   mcu_strobe,
  output logic                     mcu_start,
  output logic [7:0]               mcu_dout,
  output logic [7:0]               mcu_target,
  input  logic [8*NUM_TARGETS-1:0] mcu_din,
  output logic                     mcu_frame_end,
  output logic                     mcu_bad_target
);

  localparam logic [7:0] NumTargets8 = 8'(NUM_TARGETS);

  logic [SYNC_STAGES-1:0] ssSync_q, sclkSync_q, dinSync_q;
  logic [SYNC_STAGES-1:0] warm_q;
  logic                   armed_q, armed_d;
  logic                   sclkPrev_q;
  logic                   ssPrev_q;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bitCnt_q, bitCnt_d;
  logic [3:0]             byteCnt_q, byteCnt_d;
  logic [7:0]             target_q, target_d;
  logic [7:0]             data_q, data_d;
  logic [NUM_TARGETS-1:0] strobe_q, strobe_d;
  logic                   bad_q, bad_d;
  logic                   start_q, start_d;
  logic                   frameEnd_q, frameEnd_d;
  logic                   miso_q, miso_d;

  logic                   ss, sclk, din;
  logic                   active, sclkRise, sclkFall, targetValid;
  logic [7:0]             txByte, rxByte;
  logic [NUM_TARGETS-1:0] strobeSel;

  assign ss   = ssSync_q[SYNC_STAGES-1];
  assign sclk = sclkSync_q[SYNC_STAGES-1];
  assign din  = dinSync_q[SYNC_STAGES-1];

  // A frame only counts once ss has been seen high after reset, so a frame cut by reset is never resumed.
  assign active   = ~ss & armed_q;
  assign sclkRise = active & sclk & ~sclkPrev_q;
  assign sclkFall = active & ~sclk & sclkPrev_q;

  assign targetValid = target_q < NumTargets8;
  assign rxByte      = {shift_q[6:0], din};

  always_comb begin
    txByte    = 8'h00;
    strobeSel = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (target_q == 8'(k)) begin
        strobeSel[k] = 1'b1;
        if (byteCnt_q != 4'd0) begin
          txByte = mcu_din[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    byteCnt_d  = byteCnt_q;
    target_d   = target_q;
    data_d     = data_q;
    strobe_d   = '0;
    bad_d      = 1'b0;
    miso_d     = miso_q;
    frameEnd_d = ss & ~ssPrev_q;
    armed_d    = armed_q | (warm_q[SYNC_STAGES-1] & ss);
    start_d    = active & (byteCnt_q == 4'd2);

    if (!active) begin
      bitCnt_d  = 3'd0;
      byteCnt_d = 4'd0;
      miso_d    = 1'b0;
    end else begin
      if (sclkRise) begin
        miso_d = txByte[3'd7 - bitCnt_q];
      end
      if (sclkFall) begin
        shift_d  = rxByte;
        bitCnt_d = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          if (byteCnt_q == 4'd0) begin
            target_d = rxByte;
          end else begin
            data_d = rxByte;
            if (targetValid) begin
              strobe_d = strobeSel;
            end else begin
              bad_d = 1'b1;
            end
          end
          if (byteCnt_q != 4'd15) begin
            byteCnt_d = byteCnt_q + 4'd1;
          end
        end
      end
    end
  end

  // warm_q marks when the synchroniser output reflects pin samples taken after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ssSync_q   <= '1;
      sclkSync_q <= '0;
      dinSync_q  <= '0;
      warm_q     <= '0;
      armed_q    <= 1'b0;
      sclkPrev_q <= 1'b0;
      ssPrev_q   <= 1'b1;
      shift_q    <= 8'h00;
      bitCnt_q   <= 3'd0;
      byteCnt_q  <= 4'd0;
      target_q   <= 8'h00;
      data_q     <= 8'h00;
      strobe_q   <= '0;
      bad_q      <= 1'b0;
      start_q    <= 1'b0;
      frameEnd_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], spi_io_ss};
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi_io_clk};
      dinSync_q  <= {dinSync_q[SYNC_STAGES-2:0], spi_io_din};
      warm_q     <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      armed_q    <= armed_d;
      sclkPrev_q <= sclk;
      ssPrev_q   <= ss;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      byteCnt_q  <= byteCnt_d;
      target_q   <= target_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      bad_q      <= bad_d;
      start_q    <= start_d;
      frameEnd_q <= frameEnd_d;
      miso_q     <= miso_d;
    end
  end

  assign spi_io_dout    = miso_q;
  assign mcu_strobe     = strobe_q;
  assign mcu_start      = start_q;
  assign mcu_dout       = data_q;
  assign mcu_target     = target_q;
  assign mcu_frame_end  = frameEnd_q;
  assign mcu_bad_target = bad_q;

endmodule

// File: tb/tb_mcu_spi_sync.sv
// Bench for mcu_spi_sync: drives MCU-style SPI frames and checks core-side events and MISO
// against a frame-level model (target from byte 0, one event per completed data byte).
module tb_mcu_spi_sync;

  localparam int NT   = 4;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_io_ss, spi_io_clk, spi_io_din;
  logic        spi_io_dout;
  logic [3:0]  mcu_strobe;
  logic        mcu_start;
  logic [7:0]  mcu_dout, mcu_target;
  logic [31:0] mcu_din;
  logic        mcu_frame_end, mcu_bad_target;

  always #5 clk = ~clk;

  mcu_spi_sync #(.NUM_TARGETS(NT), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_io_ss      (spi_io_ss),
    .spi_io_clk     (spi_io_clk),
    .spi_io_din     (spi_io_din),
    .spi_io_dout    (spi_io_dout),
    .mcu_strobe     (mcu_strobe),
    .mcu_start      (mcu_start),
    .mcu_dout       (mcu_dout),
    .mcu_target     (mcu_target),
    .mcu_din        (mcu_din),
    .mcu_frame_end  (mcu_frame_end),
    .mcu_bad_target (mcu_bad_target)
  );

  int checks = 0;
  int errors = 0;

  // Event recorder: every output pulse is logged with the cycle it was seen in.
  int         cyc = 0;
  logic [3:0] strobeValQ[$];
  logic [7:0] strobeDoutQ[$];
  int         evtQ[$];
  int         startQ[$];
  int         badCnt = 0;
  int         feCnt  = 0;

  always @(negedge clk) begin
    cyc++;
    if (mcu_strobe != 4'd0) begin
      strobeValQ.push_back(mcu_strobe);
      strobeDoutQ.push_back(mcu_dout);
    end
    if (mcu_strobe != 4'd0 || mcu_bad_target) evtQ.push_back(cyc);
    if (mcu_bad_target) badCnt++;
    if (mcu_frame_end) feCnt++;
    if (mcu_start) startQ.push_back(cyc);
  end

  logic [7:0] frameQ[$];
  logic [7:0] misoQ[$];
  logic [7:0] expTarget = 8'h00;
  logic [7:0] expDout   = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".miso"},     32'(spi_io_dout),    32'd0);
    checkOutput({tag, ".strobe"},   32'(mcu_strobe),     32'd0);
    checkOutput({tag, ".start"},    32'(mcu_start),      32'd0);
    checkOutput({tag, ".dout"},     32'(mcu_dout),       32'd0);
    checkOutput({tag, ".target"},   32'(mcu_target),     32'd0);
    checkOutput({tag, ".frameEnd"}, 32'(mcu_frame_end),  32'd0);
    checkOutput({tag, ".bad"},      32'(mcu_bad_target), 32'd0);
  endtask

  // MCU side of mode 1: shift MOSI on the rising edge, sample MISO just before the falling edge.
  task automatic shiftBits(input int totalBits);
    logic [7:0] rx;
    logic [7:0] b;
    logic [2:0] bitIdx;
    rx = 8'h00;
    for (int i = 0; i < totalBits; i++) begin
      b          = frameQ[i / 8];
      bitIdx     = 3'(7 - (i % 8));
      spi_io_clk = 1'b1;
      spi_io_din = b[bitIdx];
      repeat (HALF) @(negedge clk);
      rx         = {rx[6:0], spi_io_dout};
      spi_io_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i % 8 == 7) misoQ.push_back(rx);
    end
  endtask

  task automatic applyStimulus(input int totalBits);
    spi_io_ss = 1'b0;
    repeat (6) @(negedge clk);
    shiftBits(totalBits);
    repeat (4) @(negedge clk);
    spi_io_ss = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic runAndCheck(input string name, input int totalBits);
    int         sBase, eBase, stBase, bBase, fBase;
    int         nComp, nData, t, nStart, firstS, lastS;
    logic       valid;
    logic [7:0] expMiso;
    sBase  = strobeValQ.size();
    eBase  = evtQ.size();
    stBase = startQ.size();
    bBase  = badCnt;
    fBase  = feCnt;
    misoQ.delete();
    applyStimulus(totalBits);

    nComp = totalBits / 8;
    nData = (nComp > 0) ? nComp - 1 : 0;
    t     = int'(frameQ[0]);
    valid = (nComp > 0) ? (t < NT) : (int'(expTarget) < NT);
    if (nComp > 0) expTarget = frameQ[0];
    if (nData > 0) expDout = frameQ[nComp-1];

    checkOutput($sformatf("%s.strobeCount", name), strobeValQ.size() - sBase, valid ? nData : 0);
    checkOutput($sformatf("%s.badCount", name), badCnt - bBase, valid ? 0 : nData);
    for (int i = 0; i < nData && valid && (sBase + i) < strobeValQ.size(); i++) begin
      checkOutput($sformatf("%s.strobe%0d", name, i), 32'(strobeValQ[sBase+i]), 32'(1) << t);
      checkOutput($sformatf("%s.strobeDout%0d", name, i), 32'(strobeDoutQ[sBase+i]), 32'(frameQ[i+1]));
    end
    checkOutput($sformatf("%s.frameEnd", name), feCnt - fBase, 1);
    checkOutput($sformatf("%s.target", name), 32'(mcu_target), 32'(expTarget));
    checkOutput($sformatf("%s.dout", name), 32'(mcu_dout), 32'(expDout));

    checkOutput($sformatf("%s.misoBytes", name), misoQ.size(), nComp);
    for (int j = 0; j < misoQ.size(); j++) begin
      expMiso = (j == 0 || !valid) ? 8'h00 : 8'(mcu_din >> (8 * t));
      checkOutput($sformatf("%s.miso%0d", name, j), 32'(misoQ[j]), 32'(expMiso));
    end

    // mcu_start: rises the cycle after the first data-byte event, drops around the second one.
    nStart = startQ.size() - stBase;
    if (nData == 0) begin
      checkOutput($sformatf("%s.startCount", name), nStart, 0);
    end else if (nStart == 0) begin
      checkOutput($sformatf("%s.startSeen", name), 32'd0, 32'd1);
    end else begin
      firstS = startQ[stBase];
      lastS  = startQ[startQ.size()-1];
      checkOutput($sformatf("%s.startFirst", name), firstS, evtQ[eBase] + 1);
      checkOutput($sformatf("%s.startContig", name), nStart, lastS - firstS + 1);
      if (nData >= 2) begin
        checkOutput($sformatf("%s.startLast", name),
                    32'((lastS == evtQ[eBase+1]) || (lastS == evtQ[eBase+1] - 1)), 32'd1);
      end
    end
  endtask

  initial begin
    int sBase, bBase, nb;
    reset_n    = 1'b0;
    spi_io_ss  = 1'b1;
    spi_io_clk = 1'b0;
    spi_io_din = 1'b0;
    mcu_din    = 32'h0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    mcu_din = $urandom;
    frameQ  = '{8'h02, 8'hA5, 8'h3C};
    runAndCheck("write", 24);

    mcu_din = {16'h5A5A, 8'h96, 8'h77};
    frameQ  = '{8'h01, 8'h00};
    runAndCheck("readback", 16);

    mcu_din = $urandom;
    frameQ  = '{8'h07, 8'h11, 8'h22};
    runAndCheck("badTarget", 24);

    frameQ = '{8'h02, 8'h5A};
    runAndCheck("abort", 13);

    frameQ = '{8'h00, 8'h11};
    runAndCheck("afterAbort", 16);

    mcu_din = $urandom;
    frameQ.delete();
    frameQ.push_back(8'h03);
    for (int i = 1; i < 20; i++) frameQ.push_back(8'($urandom));
    runAndCheck("longFrame", 160);

    // Reset in the middle of a frame, then clock bits without a fresh ss fall.
    frameQ    = '{8'h01, 8'hFF, 8'hFF};
    spi_io_ss = 1'b0;
    repeat (6) @(negedge clk);
    shiftBits(12);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("midReset");
    reset_n = 1'b1;
    sBase   = strobeValQ.size();
    bBase   = badCnt;
    repeat (4) @(negedge clk);
    shiftBits(16);
    repeat (4) @(negedge clk);
    spi_io_ss = 1'b1;
    repeat (10) @(negedge clk);
    expTarget = 8'h00;
    expDout   = 8'h00;
    checkOutput("postReset.strobeCount", strobeValQ.size() - sBase, 0);
    checkOutput("postReset.badCount", badCnt - bBase, 0);
    checkOutput("postReset.target", 32'(mcu_target), 32'(expTarget));
    checkOutput("postReset.dout", 32'(mcu_dout), 32'(expDout));

    for (int r = 0; r < 12; r++) begin
      mcu_din = $urandom;
      nb      = int'($urandom_range(2, 5));
      frameQ.delete();
      frameQ.push_back(8'($urandom_range(0, 5)));
      for (int i = 1; i < nb; i++) frameQ.push_back(8'($urandom));
      runAndCheck($sformatf("rand%0d", r), nb * 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_spi_sync.md
# mcu_spi_sync

Parametrised, single-clock successor to the MCU SPI byte interface. It oversamples the MCU's SPI mode-1 lines in the core clock domain, so no logic runs on the SPI clock. It decodes the first byte of each frame as a target ID and fans data bytes out to `NUM_TARGETS` byte-wide core targets (sys, HID, OSD, SDC, …). It returns the selected target's read byte on MISO and flags frame end and unknown targets.

## Interface
- `NUM_TARGETS`, 4: number of byte targets, legal range 1..16.
- `SYNC_STAGES`, 2: synchroniser depth on `spi_io_ss`/`spi_io_clk`/`spi_io_din`, legal range 2..3.
- `clk`  in  1  core clock; sole clock of the block.
- `reset_n`  in  1  synchronous, active-low reset.
- `spi_io_ss`  in  1  SPI select, active low, asynchronous to `clk`.
- `spi_io_clk`  in  1  SPI clock, mode 1, asynchronous.
- `spi_io_din`  in  1  MOSI, MSB first.
- `spi_io_dout`  out  1  MISO, registered.
- `mcu_strobe`  out  NUM_TARGETS  one-hot, 1-cycle pulse per data byte to `mcu_target`.
- `mcu_start`  out  1  high while the frame is active and `byte_cnt`==2.
- `mcu_dout`  out  8  last received data byte; holds until the next data byte.
- `mcu_target`  out  8  target ID of the current/last frame.
- `mcu_din`  in  8*NUM_TARGETS  read bytes; target k occupies bits [8k+7:8k].
- `mcu_frame_end`  out  1  1-cycle pulse on synchronised `ss` rising edge.
- `mcu_bad_target`  out  1  1-cycle pulse per data byte addressed to ID ≥ NUM_TARGETS.

## Operation
- **Synchronisers**
  - Each SPI input passes through SYNC_STAGES flops.
  - Reset values: `ss`=1, `clk`=0, `din`=0.
  - `sclk_d` holds the previous synchronised `sclk`.
- **Frame state**
  - Active when synchronised `ss`=0.
  - While synchronised `ss`=1: `bit_cnt` (3 b) and `byte_cnt` (4 b) are held at 0; `spi_io_dout`=0; no strobes.
  - `mcu_target`, `mcu_dout` and the receive shift register are retained.
- **Receive** (falling edge: `sclk`=0 and `sclk_d`=1, frame active)
  - Shift `din` into the shift register MSB-first.
  - `bit_cnt`++ with wrap 7→0.
  - When `bit_cnt`==7, the completed byte is processed on the next cycle:
    - If `byte_cnt`==0, `mcu_target` ← byte.
    - Otherwise `mcu_dout` ← byte, plus either `mcu_strobe[mcu_target]`=1 if `mcu_target` < NUM_TARGETS, or `mcu_bad_target`=1.
    - `byte_cnt`++, saturating at 15; strobes continue past saturation.
- **Transmit** (rising edge: `sclk`=1 and `sclk_d`=0, frame active)
  - `spi_io_dout` ← `tx[7-bit_cnt]`.
  - `tx` = `mcu_din` slice of `mcu_target` when `byte_cnt`≥1 and the target is valid; otherwise 0x00.
  - `tx` is sampled live, so the target may change `mcu_din` after its strobe.
- **Frame end**
  - A synchronised `ss` rising edge pulses `mcu_frame_end` and clears the counters.
  - A partial byte is discarded: no strobe, no `mcu_dout` update.
- **Simultaneous events**
  - If synchronised `ss` is 1 in the same cycle as a detected SCLK edge, the edge is ignored.
  - An SCLK edge in the cycle after an `ss` falling edge is processed normally.
- **Reset** (`reset_n`=0 at a `clk` edge), including mid-frame:
  - `spi_io_dout`=0, `mcu_strobe`=0, `mcu_start`=0, `mcu_dout`=0x00, `mcu_target`=0x00, `mcu_frame_end`=0, `mcu_bad_target`=0.
  - Counters and shift register are 0; synchronisers take their reset values.
  - After release, the block waits for a fresh `ss` falling edge; an in-progress frame is not resumed.

## Timing
- Let E be the cycle in which the falling SCLK edge is detected. E occurs SYNC_STAGES+1 `clk` edges after the pin edge, ±1 cycle of sampling jitter.
- Byte completing at E: `mcu_strobe`/`mcu_bad_target` are high in E+1 only. `mcu_dout`/`mcu_target` are valid from E+1.
- `spi_io_dout` updates at the end of the rising-edge detect cycle. Pin latency is SYNC_STAGES+2 `clk` cycles.
- Required SCLK high and low times are each ≥ SYNC_STAGES+3 `clk` periods. At SYNC_STAGES=2 this is SCLK ≤ `clk`/10.
- MCU setup margin: the MCU samples MISO on its own falling edge, ≥ half an SCLK period after the rising edge.
- `mcu_start` goes high in the cycle after the 2nd byte's strobe and stays high until the 3rd byte completes or the frame ends.

## Test plan
- **Reset:** `reset_n`=0 for 2 cycles mid-frame → all outputs 0. After release, bits clocked before a new `ss` fall produce no strobe.
- **Write frame:** NUM_TARGETS=4, SCLK=`clk`/16, frame 0x02,0xA5,0x3C → `mcu_strobe`=4'b0100 pulses twice; `mcu_dout`=0xA5 then 0x3C; `mcu_target`=0x02; `mcu_start` high between the two strobes; one `mcu_frame_end`.
- **Readback:** frame 0x01,0x00 with `mcu_din[15:8]`=0x96 → MISO during byte 0 is 0,0,0,0,0,0,0,0; during byte 1 it is 1,0,0,1,0,1,1,0.
- **Bad target:** frame 0x07,0x11,0x22 → `mcu_strobe` never asserts; `mcu_bad_target` pulses twice; MISO all 0; `mcu_dout`=0x22.
- **Abort mid-byte:** `ss` rises after 5 bits of byte 1 → no strobe, `mcu_dout` unchanged, `mcu_frame_end` pulses. The next frame 0x00,0x11 gives `mcu_strobe[0]` once and `mcu_dout`=0x11.
- **Long frame:** 20-byte frame to target 3 → 19 strobes on `mcu_strobe[3]`; `byte_cnt` holds 15; `mcu_start` high only in its byte-2 window.
